// File: rtl/fetch_pkg.sv
// Shared types for the fetch prefetch buffer: FSM states, the default
// queue depth and the queue entry layout {pc, instr}.
package fetch_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int ENTRY_W       = 96;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Circular instruction queue holding {pc, instr} entries. Flush empties it
// in one cycle. The head entry reads as zero whenever the queue is empty.
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ENTRY_W-1:0]       din,
  output logic [ENTRY_W-1:0]       dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic               w_rd_en;
  logic               w_wr_en;

  assign empty   = (r_count == '0);
  assign full    = (r_count == CW'(DEPTH));
  assign count   = r_count;
  assign w_rd_en = pop && !empty;
  assign w_wr_en = push && (!full || w_rd_en);
  assign dout    = empty ? '0 : r_mem[r_rd_ptr];

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; flush wins over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches to instruction
// memory, queues the returned words with their addresses and hands them to
// the IF/ID register. A redirect flushes the queue and drops any response
// still in flight. Optional performance counters are built when the macro
// PREFETCH_PERF_EN is defined.
module fetch_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_mem_req;
  logic          w_req_nxt;
  logic [63:0]   r_mem_addr;
  logic [63:0]   w_addr_nxt;
  logic [63:0]   r_fetch_pc;
  logic [63:0]   w_pc_nxt;
  logic [63:0]   w_pc_plus4;
  logic [63:0]   w_redirect_pc;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ_nxt;
  logic          w_can_issue;
  entry_t        w_din;
  entry_t        w_dout;

  assign w_pc_plus4    = r_fetch_pc + 64'd4;
  assign w_redirect_pc = redirect_pc & ~64'd3;

  // Redirect suppresses both queue movements; the flush clears everything.
  assign w_push = (r_state == ST_WAIT) && mem_ack && !redirect;
  assign w_pop  = !w_empty && instr_ready && !redirect;

  // A new request needs a free slot after this cycle's push/pop, so the
  // outstanding request plus occupancy can never exceed DEPTH.
  assign w_occ_nxt   = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_can_issue = w_pop || (!w_full && (w_occ_nxt < DEPTH_W));

  assign w_din = '{pc: r_mem_addr, instr: mem_rdata};

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Request FSM: next state, request strobe, request address and fetch pc.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_mem_req;
    w_addr_nxt  = r_mem_addr;
    w_pc_nxt    = r_fetch_pc;
    case (r_state)
      ST_IDLE: begin
        if (redirect) begin
          w_pc_nxt = w_redirect_pc;
        end else if (w_can_issue) begin
          w_state_nxt = ST_WAIT;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          w_pc_nxt = w_redirect_pc;
          if (mem_ack) begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
          end else begin
            // Keep the request up until memory answers, then drop the data.
            w_state_nxt = ST_DISCARD;
          end
        end else if (mem_ack) begin
          w_pc_nxt = w_pc_plus4;
          if (w_can_issue) begin
            w_addr_nxt = w_pc_plus4;
          end else begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
          end
        end
      end
      ST_DISCARD: begin
        if (redirect) w_pc_nxt = w_redirect_pc;
        if (mem_ack) begin
          w_state_nxt = ST_IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // FSM and request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_req_nxt;
      r_mem_addr <= w_addr_nxt;
      r_fetch_pc <= w_pc_nxt;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = !w_empty;
  assign instr       = w_dout.instr;
  assign instr_pc    = w_dout.pc;

`ifdef PREFETCH_PERF_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Free-running event counters for queued instructions and redirects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetch_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_push)   r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (redirect) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: a per-cycle vector table (inputs driven on
// the falling edge, registered outputs compared 1ns later) plus a
// variable-latency memory sequence and, with PREFETCH_PERF_EN, a counter check.
module tb_fetch_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (64'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          ack;
    logic [31:0] rdata;
    bit          redir;
    logic [63:0] rpc;
    bit          rdy;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_vld;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(bit rst, bit ack, logic [31:0] rdata, bit redir,
                              logic [63:0] rpc, bit rdy, bit e_req,
                              logic [63:0] e_addr, bit e_vld,
                              logic [31:0] e_instr, logic [63:0] e_pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_instr = e_instr; v.e_pc = e_pc;
    tbl.push_back(v);
  endfunction

  initial begin
    // Zero-wait memory, consumer always ready.
    add(1, 0, 0,            0, 0,      1, 0, 64'h0,   0, 0,            0);
    add(0, 0, 0,            0, 0,      1, 0, 64'h0,   0, 0,            0);
    add(0, 1, 32'h1111_0000, 0, 0,     1, 1, 64'h0,   0, 0,            0);
    add(0, 1, 32'h1111_0001, 0, 0,     1, 1, 64'h4,   1, 32'h1111_0000, 64'h0);
    add(0, 1, 32'h1111_0002, 0, 0,     1, 1, 64'h8,   1, 32'h1111_0001, 64'h4);
    add(0, 0, 0,            0, 0,      1, 1, 64'hC,   1, 32'h1111_0002, 64'h8);
    add(0, 0, 0,            0, 0,      1, 1, 64'hC,   0, 0,            0);
    // Stalled consumer fills DEPTH=4 entries, then request stops until a pop.
    add(1, 0, 0,            0, 0,      0, 0, 64'h0,   0, 0,            0);
    add(0, 0, 0,            0, 0,      0, 0, 64'h0,   0, 0,            0);
    add(0, 1, 32'h2222_0000, 0, 0,     0, 1, 64'h0,   0, 0,            0);
    add(0, 1, 32'h2222_0001, 0, 0,     0, 1, 64'h4,   1, 32'h2222_0000, 64'h0);
    add(0, 1, 32'h2222_0002, 0, 0,     0, 1, 64'h8,   1, 32'h2222_0000, 64'h0);
    add(0, 1, 32'h2222_0003, 0, 0,     0, 1, 64'hC,   1, 32'h2222_0000, 64'h0);
    add(0, 1, 32'hDEAD_0000, 0, 0,     0, 0, 64'hC,   1, 32'h2222_0000, 64'h0);
    add(0, 0, 0,            0, 0,      1, 0, 64'hC,   1, 32'h2222_0000, 64'h0);
    add(0, 0, 0,            0, 0,      0, 1, 64'h10,  1, 32'h2222_0001, 64'h4);
    add(0, 0, 0,            0, 0,      1, 1, 64'h10,  1, 32'h2222_0001, 64'h4);
    add(0, 0, 0,            0, 0,      0, 1, 64'h10,  1, 32'h2222_0002, 64'h8);
    // Redirect to 0x103 while a request is pending; late data is dropped.
    add(1, 0, 0,            0, 0,      1, 0, 64'h0,   0, 0,            0);
    add(0, 0, 0,            0, 0,      1, 0, 64'h0,   0, 0,            0);
    add(0, 1, 32'h3333_0000, 0, 0,     0, 1, 64'h0,   0, 0,            0);
    add(0, 0, 0,            0, 0,      0, 1, 64'h4,   1, 32'h3333_0000, 64'h0);
    add(0, 0, 0,            1, 64'h103, 0, 1, 64'h4,  1, 32'h3333_0000, 64'h0);
    add(0, 0, 0,            0, 0,      0, 1, 64'h4,   0, 0,            0);
    add(0, 0, 0,            0, 0,      0, 1, 64'h4,   0, 0,            0);
    add(0, 1, 32'hBAD0_0000, 0, 0,     1, 1, 64'h4,   0, 0,            0);
    add(0, 0, 0,            0, 0,      1, 0, 64'h4,   0, 0,            0);
    add(0, 1, 32'h3333_0100, 0, 0,     1, 1, 64'h100, 0, 0,            0);
    add(0, 0, 0,            0, 0,      1, 1, 64'h104, 1, 32'h3333_0100, 64'h100);
    add(0, 0, 0,            0, 0,      1, 1, 64'h104, 0, 0,            0);
    // Redirect together with ack and pop while the slots are fully reserved.
    add(1, 0, 0,            0, 0,      0, 0, 64'h0,   0, 0,            0);
    add(0, 0, 0,            0, 0,      0, 0, 64'h0,   0, 0,            0);
    add(0, 1, 32'h4444_0000, 0, 0,     0, 1, 64'h0,   0, 0,            0);
    add(0, 1, 32'h4444_0001, 0, 0,     0, 1, 64'h4,   1, 32'h4444_0000, 64'h0);
    add(0, 1, 32'h4444_0002, 0, 0,     0, 1, 64'h8,   1, 32'h4444_0000, 64'h0);
    add(0, 1, 32'h4444_0003, 1, 64'h200, 1, 1, 64'hC, 1, 32'h4444_0000, 64'h0);
    add(0, 0, 0,            0, 0,      1, 0, 64'hC,   0, 0,            0);
    // Unaligned redirect to the top of the address space, then wrap to 0.
    add(0, 0, 0,            1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h200, 0, 0, 0);
    add(0, 1, 32'hBAD0_0001, 0, 0,     1, 1, 64'h200, 0, 0,            0);
    add(0, 0, 0,            0, 0,      0, 0, 64'h200, 0, 0,            0);
    add(0, 1, 32'h5555_0000, 0, 0,     0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    add(0, 0, 0,            0, 0,      0, 1, 64'h0,   1, 32'h5555_0000, 64'hFFFF_FFFF_FFFF_FFFC);
    // Reset mid-request; a stray ack after release must not push anything.
    add(1, 0, 0,            0, 0,      1, 0, 64'h0,   0, 0,            0);
    add(0, 1, 32'hBAD0_0002, 0, 0,     1, 0, 64'h0,   0, 0,            0);
    add(0, 0, 0,            0, 0,      1, 1, 64'h0,   0, 0,            0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset       = tbl[i].rst;
      mem_ack     = tbl[i].ack;
      mem_rdata   = tbl[i].rdata;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      instr_ready = tbl[i].rdy;
      #1;
      total++;
      if (mem_req !== tbl[i].e_req || mem_addr !== tbl[i].e_addr ||
          instr_valid !== tbl[i].e_vld ||
          ((tbl[i].rst || tbl[i].e_vld) &&
           (instr !== tbl[i].e_instr || instr_pc !== tbl[i].e_pc))) begin
        bad++;
        $display("FAIL row%0d: got req=%b addr=%h vld=%b instr=%h pc=%h, want req=%b addr=%h vld=%b instr=%h pc=%h",
                 i, mem_req, mem_addr, instr_valid, instr, instr_pc,
                 tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_instr, tbl[i].e_pc);
      end
    end

    // Two-cycle memory latency with a consumer that stalls every third cycle;
    // the stream must continue in order from address 0.
    begin
      int got;
      int lat;
      logic [63:0] epc;
      got = 0;
      lat = 0;
      for (int c = 0; c < 300 && got < 6; c++) begin
        @(negedge clk);
        if (mem_req) begin
          if (lat == 2) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_addr[31:0] ^ 32'hA5A5_0000;
            lat       = 0;
          end else begin
            mem_ack = 1'b0;
            lat++;
          end
        end else begin
          mem_ack = 1'b0;
          lat     = 0;
        end
        instr_ready = ((c % 3) != 1);
        #1;
        if (instr_valid && instr_ready) begin
          epc = 64'(got * 4);
          total++;
          if (instr_pc !== epc || instr !== (epc[31:0] ^ 32'hA5A5_0000)) begin
            bad++;
            $display("FAIL latency_stream%0d: got pc=%h instr=%h, want pc=%h instr=%h",
                     got, instr_pc, instr, epc, epc[31:0] ^ 32'hA5A5_0000);
          end
          got++;
        end
      end
      total++;
      if (got < 6) begin
        bad++;
        $display("FAIL latency_timeout: got %0d instructions, want 6", got);
      end
      mem_ack = 1'b0;
    end

`ifdef PREFETCH_PERF_EN
    @(negedge clk);
    reset       = 1'b1;
    mem_ack     = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b1;
    #1;
    total++;
    if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_reset: got fetch=%0d flush=%0d, want 0 0",
               perf_fetch_cnt, perf_flush_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 32'h6666_0000 + 32'(k);
    end
    @(negedge clk);
    mem_ack     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    @(negedge clk);
    redirect = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    total++;
    if (perf_fetch_cnt !== 32'd10 || perf_flush_cnt !== 32'd2) begin
      bad++;
      $display("FAIL perf_counts: got fetch=%0d flush=%0d, want 10 2",
               perf_fetch_cnt, perf_flush_cnt);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
